// File: rtl/ysyx_25040101_imm_pkg.sv
// Shared types and constants for the immediate-generation stage.
// This file holds the immediate format codes and the XLEN-dependent shift-amount width.
package ysyx_25040101_imm_pkg;

    localparam int IMM_TYPE_W = 3;
    localparam int INST_W     = 32;

    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_type_e;

    // RV64 shifts use a 6-bit shamt; RV32 uses 5 bits.
    function automatic int shamt_w(input int xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

// File: rtl/ysyx_25040101_imm_decode.sv
// Combinational immediate extraction: instruction word and format code to an XLEN immediate.
// It sign-extends the RISC-V immediate formats and zero-extends the shamt and CSR zimm fields.
module ysyx_25040101_imm_decode
    import ysyx_25040101_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INST_W-1:0]     inst_i,
    input  logic [IMM_TYPE_W-1:0] imm_type_i,
    output logic [XLEN-1:0]       imm_o
);

    localparam int SHAMT_W = shamt_w(XLEN);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("ysyx_25040101_imm_decode: XLEN must be 32 or 64");
    end

    logic signed [11:0] imm_i_p0;
    logic signed [11:0] imm_s_p0;
    logic signed [12:0] imm_b_p0;
    logic signed [31:0] imm_u_p0;
    logic signed [20:0] imm_j_p0;
    logic               unused_opcode;

    assign imm_i_p0 = inst_i[31:20];
    assign imm_s_p0 = {inst_i[31:25], inst_i[11:7]};
    assign imm_b_p0 = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u_p0 = {inst_i[31:12], 12'b0};
    assign imm_j_p0 = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Opcode bits carry no immediate information.
    assign unused_opcode = ^inst_i[6:0];

    always_comb begin
        imm_o = '0;
        case (imm_type_e'(imm_type_i))
            IMM_NONE:  imm_o = '0;
            IMM_I:     imm_o = XLEN'(imm_i_p0);
            IMM_S:     imm_o = XLEN'(imm_s_p0);
            IMM_B:     imm_o = XLEN'(imm_b_p0);
            IMM_U:     imm_o = XLEN'(imm_u_p0);
            IMM_J:     imm_o = XLEN'(imm_j_p0);
            IMM_SHAMT: imm_o = XLEN'(inst_i[20 +: SHAMT_W]);
            IMM_ZIMM:  imm_o = XLEN'(inst_i[19:15]);
            default:   imm_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_25040101_imm_stage.sv
// Registered immediate-generation stage: the decoder feeds a two-entry output/skid buffer
// behind valid/ready, so in_ready_o never depends combinationally on out_ready_i.
module ysyx_25040101_imm_stage
    import ysyx_25040101_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [INST_W-1:0]     inst_i,
    input  logic [IMM_TYPE_W-1:0] imm_type_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [XLEN-1:0]       imm_o,
    output logic [TAG_W-1:0]      tag_o
);

    logic [XLEN-1:0]  imm_p0;
    logic             out_vld_p1;
    logic             skid_vld_p1;
    logic [XLEN-1:0]  out_imm_p1;
    logic [XLEN-1:0]  skid_imm_p1;
    logic [TAG_W-1:0] out_tag_p1;
    logic [TAG_W-1:0] skid_tag_p1;

    logic accept;
    logic advance;
    logic move_skid;
    logic load_out;
    logic load_skid;

    // ---- p0: decode at accept ----
    ysyx_25040101_imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst_i     (inst_i),
        .imm_type_i (imm_type_i),
        .imm_o      (imm_p0)
    );

    // OUT can take a new entry when it is empty or drains this cycle; SKID always refills OUT first.
    assign accept    = in_valid_i & in_ready_o & ~flush_i;
    assign advance   = ~out_vld_p1 | (out_vld_p1 & out_ready_i);
    assign move_skid = advance & skid_vld_p1 & ~flush_i;
    assign load_out  = accept & advance & ~skid_vld_p1;
    assign load_skid = accept & ~load_out;

    // ---- p1: output / skid buffer ----
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (flush_i) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else begin
            if (advance) begin
                out_vld_p1 <= skid_vld_p1 | accept;
            end
            skid_vld_p1 <= (skid_vld_p1 & ~move_skid) | load_skid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_imm_p1 <= '0;
            out_tag_p1 <= '0;
        end else if (move_skid) begin
            out_imm_p1 <= skid_imm_p1;
            out_tag_p1 <= skid_tag_p1;
        end else if (load_out) begin
            out_imm_p1 <= imm_p0;
            out_tag_p1 <= tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_skid) begin
            skid_imm_p1 <= imm_p0;
            skid_tag_p1 <= tag_i;
        end
    end

    assign in_ready_o  = ~skid_vld_p1;
    assign out_valid_o = out_vld_p1;
    assign imm_o       = out_imm_p1;
    assign tag_o       = out_tag_p1;

endmodule

// File: tb/tb_ysyx_25040101_imm_stage.sv
// Bench for ysyx_25040101_imm_stage: XLEN=32 and XLEN=64 instances share one stimulus stream
// and a scoreboard of expected immediates, plus directed backpressure, flush and reset sequences.
module tb_ysyx_25040101_imm_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic [2:0]  imm_type;
    logic [7:0]  tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tag32, tag64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] imm32;
        logic [63:0] imm64;
    } sb_t;
    sb_t sb[$];
    sb_t sb_head;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [7:0]  tag;
        logic [31:0] exp32;
        logic [63:0] exp64;
    } vec_t;
    vec_t vec[13];

    ysyx_25040101_imm_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready32), .inst_i(inst), .imm_type_i(imm_type), .tag_i(tag),
        .out_valid_o(out_valid32), .out_ready_i(out_ready), .imm_o(imm32), .tag_o(tag32)
    );

    ysyx_25040101_imm_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready64), .inst_i(inst), .imm_type_i(imm_type), .tag_i(tag),
        .out_valid_o(out_valid64), .out_ready_i(out_ready), .imm_o(imm64), .tag_o(tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference immediate taken straight from the format definitions.
    function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] t, input bit x64);
        logic [63:0] v;
        case (t)
            3'd1:    v = {{52{i[31]}}, i[31:20]};
            3'd2:    v = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3:    v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    v = {{32{i[31]}}, i[31:12], 12'b0};
            3'd5:    v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd6:    v = x64 ? 64'(i[25:20]) : 64'(i[24:20]);
            3'd7:    v = 64'(i[19:15]);
            default: v = 64'd0;
        endcase
        if (!x64) v = {32'd0, v[31:0]};
        return v;
    endfunction

    // Scoreboard: pop on each transfer, push on each accept; flush drops everything buffered.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid32 && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got tag 0x%0h expected no output", tag32);
                end else begin
                    sb_head = sb.pop_front();
                    check("sb_tag", tag32, sb_head.tag);
                    check("sb_imm32", imm32, sb_head.imm32);
                    check("sb_imm64", imm64, sb_head.imm64);
                    check("sb_vld64", out_valid64, 1);
                    check("sb_tag64", tag64, sb_head.tag);
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready32) begin
                sb.push_back('{tag: tag, imm32: model_imm(inst, imm_type, 1'b0)[31:0],
                               imm64: model_imm(inst, imm_type, 1'b1)});
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] t, input logic [31:0] ins, input logic [2:0] ty);
        @(posedge clk);
        #1;
        in_valid = v;
        tag      = t;
        inst     = ins;
        imm_type = ty;
    endtask

    initial begin
        int idx;
        bit did_reset;

        vec[0]  = '{32'hFFF00093, 3'd1, 8'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vec[1]  = '{32'h7FF00093, 3'd1, 8'h12, 32'h000007FF, 64'h00000000000007FF};
        vec[2]  = '{32'hFE000EE3, 3'd3, 8'h13, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vec[3]  = '{32'h03F09093, 3'd6, 8'h14, 32'h0000001F, 64'h000000000000003F};
        vec[4]  = '{32'h000FD073, 3'd7, 8'h15, 32'h0000001F, 64'h000000000000001F};
        vec[5]  = '{32'hFFFFFFFF, 3'd0, 8'h16, 32'h00000000, 64'h0000000000000000};
        vec[6]  = '{32'hFE000C23, 3'd2, 8'h17, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8};
        vec[7]  = '{32'h02000223, 3'd2, 8'h18, 32'h00000024, 64'h0000000000000024};
        vec[8]  = '{32'h800002B7, 3'd4, 8'h19, 32'h80000000, 64'hFFFFFFFF80000000};
        vec[9]  = '{32'h123452B7, 3'd4, 8'h1A, 32'h12345000, 64'h0000000012345000};
        vec[10] = '{32'h7FE0006F, 3'd5, 8'h1B, 32'h000007FE, 64'h00000000000007FE};
        vec[11] = '{32'hFFFFF06F, 3'd5, 8'h1C, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE};
        vec[12] = '{32'h01F09093, 3'd6, 8'h1D, 32'h0000001F, 64'h000000000000001F};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0; imm_type = '0; tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid32, 0);
        check("rst_in_ready", in_ready32, 1);
        check("rst_imm32", imm32, 0);
        check("rst_tag", tag32, 0);
        check("rst_imm64", imm64, 0);
        check("rst_in_ready64", in_ready64, 1);

        // Single-entry latency and decode for every table vector.
        out_ready = 1'b1;
        foreach (vec[k]) begin
            drive(1'b1, vec[k].tag, vec[k].inst, vec[k].typ);
            @(negedge clk);
            check("tbl_in_ready", in_ready32, 1);
            drive(1'b0, 8'h00, 32'h0, 3'd0);
            @(negedge clk);
            check("tbl_out_valid", out_valid32, 1);
            check("tbl_tag", tag32, vec[k].tag);
            check("tbl_imm32", imm32, vec[k].exp32);
            check("tbl_imm64", imm64, vec[k].exp64);
        end

        // Backpressure: tags 1,2 fill the buffer, tag 3 waits.
        drive(1'b0, 8'h00, 32'h0, 3'd0);
        out_ready = 1'b0;
        drive(1'b1, 8'd1, 32'h00100093, 3'd1);
        @(negedge clk);
        check("bp_ready1", in_ready32, 1);
        drive(1'b1, 8'd2, 32'h00200093, 3'd1);
        @(negedge clk);
        check("bp_ready2", in_ready32, 1);
        check("bp_head1", tag32, 1);
        drive(1'b1, 8'd3, 32'h00300093, 3'd1);
        @(negedge clk);
        check("bp_full", in_ready32, 0);
        check("bp_hold_tag", tag32, 1);
        drive(1'b1, 8'd3, 32'h00300093, 3'd1);
        @(negedge clk);
        check("bp_full2", in_ready32, 0);
        check("bp_stable_tag", tag32, 1);
        check("bp_stable_imm", imm32, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_t1", tag32, 1);
        check("bp_still_full", in_ready32, 0);
        @(negedge clk);
        check("bp_out_t2", tag32, 2);
        check("bp_ready_back", in_ready32, 1);
        drive(1'b0, 8'h00, 32'h0, 3'd0);
        @(negedge clk);
        check("bp_out_t3", tag32, 3);
        check("bp_vld_t3", out_valid32, 1);
        @(negedge clk);
        check("bp_drained", out_valid32, 0);

        // Flush with both entries full and tag 9 offered.
        out_ready = 1'b0;
        drive(1'b1, 8'd4, 32'h00400093, 3'd1);
        drive(1'b1, 8'd5, 32'h00500093, 3'd1);
        drive(1'b1, 8'd9, 32'h00900093, 3'd1);
        flush = 1'b1;
        @(negedge clk);
        check("fl_full", in_ready32, 0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("fl_out_valid", out_valid32, 0);
        check("fl_in_ready", in_ready32, 1);
        check("fl_out_valid64", out_valid64, 0);
        repeat (3) @(negedge clk);

        // Flush while the OUT entry is consumed and a new entry is offered.
        drive(1'b1, 8'd6, 32'h00600093, 3'd1);
        drive(1'b1, 8'd7, 32'h00700093, 3'd1);
        flush = 1'b1;
        @(negedge clk);
        check("fl2_consume_tag", tag32, 6);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl2_out_valid", out_valid32, 0);
        repeat (3) @(negedge clk);

        // Random stream with reset pulsed at entry 50.
        idx = 0;
        did_reset = 1'b0;
        for (int cyc = 0; cyc < 4000 && idx < 100; cyc++) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            if (idx == 50 && !did_reset) begin
                rst_n = 1'b0;
                in_valid = 1'b1;
                tag = 8'd50;
                @(negedge clk);
                idx++;
                did_reset = 1'b1;
                @(posedge clk);
                #1 rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
                @(negedge clk);
                check("mid_rst_out_valid", out_valid32, 0);
                check("mid_rst_in_ready", in_ready32, 1);
                check("mid_rst_imm32", imm32, 0);
                check("mid_rst_imm64", imm64, 0);
                check("mid_rst_tag", tag32, 0);
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                inst     = $urandom;
                imm_type = 3'($urandom_range(0, 7));
                tag      = 8'(idx);
                @(negedge clk);
                if (in_valid && in_ready32) idx++;
            end
        end
        check("stream_done", 64'(idx), 100);

        drive(1'b0, 8'h00, 32'h0, 3'd0);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 0);
        check("end_out_valid", out_valid32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
